// File: rtl/line_raster_pkg.sv
// Shared types and helpers for the line_raster block.
package line_raster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Signed error/delta width: two extra bits cover the sign and the 2*err term.
    function automatic int err_width(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/line_step.sv
// Combinational Bresenham step: next point and error from the current point.
module line_step
    import line_raster_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int ERR_W   = err_width(COORD_W)
) (
    input  logic [COORD_W-1:0]      i_x,
    input  logic [COORD_W-1:0]      i_y,
    input  logic signed [ERR_W-1:0] i_err,
    input  logic signed [ERR_W-1:0] i_dx,
    input  logic signed [ERR_W-1:0] i_dy,
    input  logic                    i_sx_neg,
    input  logic                    i_sy_neg,
    output logic [COORD_W-1:0]      o_x,
    output logic [COORD_W-1:0]      o_y,
    output logic signed [ERR_W-1:0] o_err
);

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    logic signed [ERR_W-1:0] w_e2;
    logic signed [ERR_W-1:0] w_err_x;
    logic signed [ERR_W-1:0] w_err_y;

    assign w_e2 = i_err <<< 1;

    // Both axis tests use the same e2, so a diagonal move updates x and y together.
    always_comb begin
        o_x     = i_x;
        o_y     = i_y;
        w_err_x = '0;
        w_err_y = '0;
        if (w_e2 >= i_dy) begin
            w_err_x = i_dy;
            o_x     = i_sx_neg ? (i_x - ONE) : (i_x + ONE);
        end else begin
            w_err_x = '0;
        end
        if (w_e2 <= i_dx) begin
            w_err_y = i_dx;
            o_y     = i_sy_neg ? (i_y - ONE) : (i_y + ONE);
        end else begin
            w_err_y = '0;
        end
        o_err = i_err + w_err_x + w_err_y;
    end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser with a valid/ready pixel stream.
// Define LINE_RASTER_CLIP_EN to suppress points outside SCREEN_W x SCREEN_H.
module line_raster
    import line_raster_pkg::*;
#(
    parameter int COORD_W  = 8,
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 64
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    output logic               o_busy,
    output logic               o_pix_valid,
    input  logic               i_pix_ready,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic               o_pix_last,
    output logic               o_done
);

    localparam int ERR_W = err_width(COORD_W);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [COORD_W-1:0]      r_x0, r_y0, r_x1, r_y1;
    logic [COORD_W-1:0]      r_x, r_y;
    logic signed [ERR_W-1:0] r_err, r_dx, r_dy;
    logic                    r_sx_neg, r_sy_neg;

    logic signed [ERR_W-1:0] w_ddx, w_ddy, w_adx, w_ndy;
    logic [COORD_W-1:0]      w_step_x, w_step_y;
    logic signed [ERR_W-1:0] w_step_err;
    logic                    w_at_end, w_in_cur, w_in_next, w_adv;

    assign w_ddx = $signed({2'b00, r_x1}) - $signed({2'b00, r_x0});
    assign w_ddy = $signed({2'b00, r_y1}) - $signed({2'b00, r_y0});
    assign w_adx = w_ddx[ERR_W-1] ? -w_ddx : w_ddx;
    assign w_ndy = w_ddy[ERR_W-1] ? w_ddy : -w_ddy;

    line_step #(.COORD_W(COORD_W), .ERR_W(ERR_W)) u_step (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_err    (r_err),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .i_sx_neg (r_sx_neg),
        .i_sy_neg (r_sy_neg),
        .o_x      (w_step_x),
        .o_y      (w_step_y),
        .o_err    (w_step_err)
    );

    assign w_at_end = (r_x == r_x1) && (r_y == r_y1);

`ifdef LINE_RASTER_CLIP_EN
    localparam logic [COORD_W:0] SW_L = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] SH_L = (COORD_W+1)'(SCREEN_H);
    // Points along a line move monotonically, so the on-screen run is contiguous
    // and the last visible pixel is the one whose successor is off-screen.
    assign w_in_cur  = ({1'b0, r_x} < SW_L) && ({1'b0, r_y} < SH_L);
    assign w_in_next = ({1'b0, w_step_x} < SW_L) && ({1'b0, w_step_y} < SH_L);
`else
    assign w_in_cur  = 1'b1;
    assign w_in_next = 1'b1;
`endif

    // Off-screen points advance without waiting for the consumer.
    assign w_adv = !w_in_cur || i_pix_ready;

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_pix_valid = (r_state == ST_STEP) && w_in_cur;
    assign o_pix_last  = o_pix_valid && (w_at_end || !w_in_next);
    assign o_pix_x     = r_x;
    assign o_pix_y     = r_y;

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_INIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_INIT: w_next_state = ST_STEP;
            ST_STEP: begin
                if (w_adv && w_at_end) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_STEP;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register and line datapath.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_err    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_x0 <= i_x0;
                        r_y0 <= i_y0;
                        r_x1 <= i_x1;
                        r_y1 <= i_y1;
                    end
                end
                ST_INIT: begin
                    r_dx     <= w_adx;
                    r_dy     <= w_ndy;
                    r_err    <= w_adx + w_ndy;
                    r_sx_neg <= (r_x1 < r_x0);
                    r_sy_neg <= (r_y1 < r_y0);
                    r_x      <= r_x0;
                    r_y      <= r_y0;
                end
                ST_STEP: begin
                    if (w_adv && !w_at_end) begin
                        r_x   <= w_step_x;
                        r_y   <= w_step_y;
                        r_err <= w_step_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster: behavioural point-list model plus directed lines.
module tb_line_raster;

    localparam int CW = 8;
    localparam int SW = 64;
    localparam int SH = 64;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_x0 = '0, i_y0 = '0, i_x1 = '0, i_y1 = '0;
    logic          i_pix_ready = 1'b1;
    logic          o_busy, o_pix_valid, o_pix_last, o_done;
    logic [CW-1:0] o_pix_x, o_pix_y;

    always #5 clk = ~clk;

    line_raster #(.COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_start     (i_start),
        .i_x0        (i_x0),
        .i_y0        (i_y0),
        .i_x1        (i_x1),
        .i_y1        (i_y1),
        .o_busy      (o_busy),
        .o_pix_valid (o_pix_valid),
        .i_pix_ready (i_pix_ready),
        .o_pix_x     (o_pix_x),
        .o_pix_y     (o_pix_y),
        .o_pix_last  (o_pix_last),
        .o_done      (o_done)
    );

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;
    typedef pix_t pq_t[$];

    pq_t exp_q;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_seen = 0;
    int  pix_cnt = 0;
    int  hold_cnt = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected pixel list: every point of the ideal line, then the screen filter.
    function automatic pq_t model_line(input int x0, input int y0, input int x1, input int y1);
        pq_t all, res;
        pix_t p;
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 >= y0) ? y0 - y1 : y1 - y0;
        sx  = (x1 >= x0) ? 1 : -1;
        sy  = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        for (int n = 0; n < 1000; n++) begin
            p.x = x; p.y = y; p.last = 1'b0;
            all.push_back(p);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        foreach (all[i]) begin
`ifdef LINE_RASTER_CLIP_EN
            if (all[i].x < SW && all[i].y < SH) res.push_back(all[i]);
`else
            res.push_back(all[i]);
`endif
        end
        if (res.size() > 0) res[res.size()-1].last = 1'b1;
        return res;
    endfunction

    // Per-cycle comparison against the head of the expected pixel queue.
    always @(negedge clk) begin
        if (chk_en && n_rst) begin
            if (o_pix_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    check("pix_x", int'(o_pix_x), exp_q[0].x);
                    check("pix_y", int'(o_pix_y), exp_q[0].y);
                    check("pix_last", int'(o_pix_last), int'(exp_q[0].last));
                    if (o_pix_x == 8'd1 && o_pix_y == 8'd0) hold_cnt++;
                    if (i_pix_ready) begin
                        void'(exp_q.pop_front());
                        pix_cnt++;
                    end
                end
            end else begin
                check("last_without_valid", int'(o_pix_last), 0);
            end
            if (o_done) begin
                done_seen++;
                check("pixels_left_at_done", exp_q.size(), 0);
                check("busy_in_done", int'(o_busy), 1);
            end
        end
    end

    // Presents a line request for exactly one sampling edge; returns just after it.
    task automatic start_line(input int x0, input int y0, input int x1, input int y1);
        @(posedge clk);
        #1;
        i_x0 = CW'(x0); i_y0 = CW'(y0); i_x1 = CW'(x1); i_y1 = CW'(y1);
        exp_q    = model_line(x0, y0, x1, y1);
        pix_cnt  = 0;
        hold_cnt = 0;
        i_start  = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Waits (bounded) for one done pulse; reports cycles spent, then checks the pulse ended.
    task automatic wait_done(input string name, output int cycles);
        int d0;
        d0 = done_seen;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            cycles++;
            if (done_seen != d0) break;
        end
        check({name, "_done_count"}, done_seen - d0, 1);
        @(negedge clk);
        #1;
        check({name, "_done_one_cycle"}, int'(o_done), 0);
        check({name, "_busy_idle"}, int'(o_busy), 0);
    endtask

    initial begin
        pq_t pq;
        int  cyc;
        int  d0;
        int  lx[6] = '{0, 1, 2, 3, 4, 5};
        int  ly[6] = '{0, 0, 1, 1, 2, 2};

        // Model pinned against hand-derived point lists.
        pq = model_line(0, 0, 5, 2);
        check("model_len_diag", pq.size(), 6);
        for (int i = 0; i < 6 && i < pq.size(); i++) begin
            check("model_diag_x", pq[i].x, lx[i]);
            check("model_diag_y", pq[i].y, ly[i]);
        end
        pq = model_line(3, 7, 3, 2);
        check("model_len_vert", pq.size(), 6);
        if (pq.size() == 6) check("model_vert_end_y", pq[5].y, 2);
        pq = model_line(2, 2, 2, 2);
        check("model_len_point", pq.size(), 1);

        // Reset state.
        #2;
        check("rst_busy", int'(o_busy), 0);
        check("rst_valid", int'(o_pix_valid), 0);
        check("rst_last", int'(o_pix_last), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_x", int'(o_pix_x), 0);
        check("rst_y", int'(o_pix_y), 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst  = 1'b1;
        chk_en = 1'b1;

        // Shallow diagonal with latency check: INIT cycle, then first pixel.
        start_line(0, 0, 5, 2);
        @(negedge clk);
        check("init_busy", int'(o_busy), 1);
        check("init_no_valid", int'(o_pix_valid), 0);
        @(negedge clk);
        check("first_valid", int'(o_pix_valid), 1);
        wait_done("diag", cyc);
        check("diag_cycles", cyc, 6);
        check("diag_pixels", pix_cnt, 6);

        // Vertical line going up in y.
        start_line(3, 7, 3, 2);
        wait_done("vert", cyc);
        check("vert_cycles", cyc, 8);
        check("vert_pixels", pix_cnt, 6);

        // Back-pressure: (1,0) held for four presented cycles.
        start_line(0, 0, 5, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        i_pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_pix_ready = 1'b1;
        wait_done("stall", cyc);
        check("stall_hold_cycles", hold_cnt, 4);
        check("stall_pixels", pix_cnt, 6);

        // Line crossing the right screen edge.
        start_line(60, 10, 70, 10);
        wait_done("edge", cyc);
`ifdef LINE_RASTER_CLIP_EN
        check("edge_pixels", pix_cnt, 4);
`else
        check("edge_pixels", pix_cnt, 11);
`endif

        // Start while stepping is ignored.
        start_line(0, 0, 5, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        i_x0 = 8'd9; i_y0 = 8'd9; i_x1 = 8'd1; i_y1 = 8'd1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done("restart", cyc);
        check("restart_pixels", pix_cnt, 6);

        // Reset during the third pixel aborts the line.
        start_line(0, 0, 5, 2);
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("abort_busy", int'(o_busy), 0);
        check("abort_valid", int'(o_pix_valid), 0);
        check("abort_last", int'(o_pix_last), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_x", int'(o_pix_x), 0);
        check("abort_y", int'(o_pix_y), 0);
        exp_q.delete();
        d0 = done_seen;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("abort_no_done", done_seen - d0, 0);
        check("abort_idle", int'(o_busy), 0);

        // Degenerate single-point line after reset.
        start_line(2, 2, 2, 2);
        wait_done("point", cyc);
        check("point_pixels", pix_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_raster.md
LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 The block SHALL expose parameter COORD_W, default 8, giving the coordinate width in bits (unsigned).
REQ-002 The block SHALL expose parameter SCREEN_W, default 64, giving the screen width in pixels for clipping.
REQ-003 The block SHALL expose parameter SCREEN_H, default 64, giving the screen height in pixels for clipping.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to draw one line; sampled only in IDLE.
REQ-007 x0, y0, x1, y1  input  COORD_W each  start and end coordinates; sampled with start.
REQ-008 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-009 pix_valid  output  1  pix_x/pix_y hold a pixel to write.
REQ-010 pix_ready  input  1  consumer accepts the pixel when pix_valid && pix_ready.
REQ-011 pix_x, pix_y  output  COORD_W each  pixel coordinates.
REQ-012 pix_last  output  1  qualifies the final pixel of the line (high only with pix_valid).
REQ-013 done  output  1  one-cycle pulse when the line completes.

Function
REQ-014 The FSM SHALL have states IDLE, INIT, STEP, DONE; IDLE->INIT on start, INIT->STEP unconditionally, STEP->DONE on acceptance of the end pixel, DONE->IDLE unconditionally.
REQ-015 In IDLE with start high, the block SHALL latch x0..y1; start in any other state SHALL be ignored.
REQ-016 INIT SHALL compute dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy, sx=+1/-1, sy=+1/-1 (sign +1 when end>=start) in signed COORD_W+2 bits, and set the current point to (x0,y0).
REQ-017 In STEP, on handshake, if current == (x1,y1) the block SHALL go to DONE; otherwise with e2=2*err: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy; both updates apply in the same cycle when both conditions hold.
REQ-018 Without handshake, pix_x, pix_y, pix_last and internal state SHALL hold stable while pix_valid is high.
REQ-019 First pix_valid SHALL assert 2 cycles after the clock edge sampling start; with pix_ready held high, one pixel per cycle.
REQ-020 Pixel count SHALL be max(dx,|dy|)+1; a degenerate line (start==end) SHALL emit exactly one pixel with pix_last=1.
REQ-021 done SHALL pulse exactly one cycle in DONE; busy SHALL drop in the same cycle IDLE is re-entered.

Reset
REQ-022 On n_rst low, state SHALL be IDLE and busy, pix_valid, pix_last, done, pix_x, pix_y SHALL be 0, asynchronously.
REQ-023 Reset mid-line SHALL abort the line with no done pulse; the next start after release SHALL draw normally.

Configuration
REQ-024 With LINE_RASTER_CLIP_EN defined, points with x>=SCREEN_W or y>=SCREEN_H SHALL not assert pix_valid; stepping SHALL continue one point per cycle without handshake; pix_last SHALL mark the last in-screen pixel; done SHALL still pulse after the end point, even if no pixel was emitted.
REQ-025 Without LINE_RASTER_CLIP_EN, every point SHALL be emitted regardless of SCREEN_W/SCREEN_H.

Structure
REQ-026 Package line_raster_pkg SHALL hold the state enum type and a function returning the error width COORD_W+2.
REQ-027 One combinational sub-module line_step SHALL compute next x, y, err from current values, dx, dy, sx, sy.

Verification
REQ-028 (0,0)->(5,2), pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2) on consecutive cycles, pix_last on (5,2), done next cycle.
REQ-029 (3,7)->(3,2) -> pixels (3,7),(3,6),(3,5),(3,4),(3,3),(3,2), six cycles.
REQ-030 (0,0)->(5,2) with pix_ready low 3 cycles while (1,0) presented -> (1,0) held stable 4 cycles, sequence otherwise unchanged.
REQ-031 (60,10)->(70,10): with LINE_RASTER_CLIP_EN -> 4 pixels x=60..63, pix_last on (63,10), done after end point; without -> 11 pixels x=60..70.
REQ-032 start pulsed during STEP -> ignored, current line unchanged; n_rst low during third pixel -> all outputs 0, no done, next start (2,2)->(2,2) emits one pixel.
